pipelined_addr: RTL and testbench

- Parametrised, pipelined multi-bit adder/subtractor for the KGP miniRISC datapath.
- Operands are split into STAGES equal chunks. Each pipeline stage adds one chunk and passes a registered carry to the next stage.
- Accepts one operation per cycle, with a valid flag travelling alongside the data, a global stall, and flag outputs (carry, signed overflow, zero) for ALU and branch logic.

---
 rtl/pipelined_addr.sv | 145 ++++++++++++++
 tb/tb_pipelined_addr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addr.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addr
// Purpose  : Pipelined WIDTH-bit adder/subtractor for the miniRISC datapath.
//            Operands are split into STAGES chunks of CHUNK bits. Each stage
//            adds one chunk and hands a registered carry to the next stage.
//            One operation per cycle is accepted, and the latency is STAGES
//            cycles. A valid bit travels with each operation. A global stall
//            freezes the whole pipe. The carry, signed-overflow and zero
//            flags are registered together with the sum.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous active-high reset
//            stall     - hold every pipeline register (in_valid ignored)
//            in_valid  - a/b/cin/sub carry a valid operation this cycle
//            a, b      - operands (WIDTH bits)
//            cin       - carry-in (borrow-in when sub=1)
//            sub       - 0 = a+b+cin, 1 = a-b-cin
//            out_valid - sum and flags are valid
//            sum       - result, modulo 2^WIDTH
//            cout      - carry out of bit WIDTH-1 (sub: 1 = no borrow)
//            ovf       - signed two's-complement overflow
//            zero      - sum == 0
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addr #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  // Inputs seen by each stage. Entry k feeds stage k.
  // The operand words are kept rotated. The chunk a stage works on always
  // sits in the low CHUNK bits. Each stage rotates right by one chunk and
  // drops its result chunk into the vacated top. After STAGES rotations the
  // word holds the finished sum in natural bit order. This is how the lower
  // result chunks ride along as the skew registers.
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_carry;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];

  assign stg_valid[0] = in_valid;
  assign stg_carry[0] = cin ^ sub;
  assign stg_a[0]     = a;
  assign stg_b[0]     = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] a_rot_d;

    assign chunk_sum = {1'b0, stg_a[k][CHUNK-1:0]}
                     + {1'b0, stg_b[k][CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, stg_carry[k]};

    if (STAGES == 1) begin : g_norot
      assign a_rot_d = chunk_sum[CHUNK-1:0];
    end else begin : g_rot
      assign a_rot_d = {chunk_sum[CHUNK-1:0], stg_a[k][WIDTH-1:CHUNK]};
    end

    if (k < STAGES - 1) begin : g_mid
      logic             valid_q;
      logic             carry_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (!stall) begin
          valid_q <= stg_valid[k];
        end
      end

      // Data registers need no reset. Their contents only matter when the
      // valid bit alongside them is set.
      always_ff @(posedge clk) begin
        if (!stall) begin
          carry_q <= chunk_sum[CHUNK];
          a_q     <= a_rot_d;
          b_q     <= {stg_b[k][CHUNK-1:0], stg_b[k][WIDTH-1:CHUNK]};
        end
      end

      assign stg_valid[k+1] = valid_q;
      assign stg_carry[k+1] = carry_q;
      assign stg_a[k+1]     = a_q;
      assign stg_b[k+1]     = b_q;
    end else begin : g_last
      logic ovf_d;
      logic zero_d;
      logic unused_b;

      // Carry into the MSB is recovered from the MSB's own sum bit:
      // s = a ^ b ^ c_in, hence c_in = a ^ b ^ s.
      assign ovf_d    = chunk_sum[CHUNK]
                      ^ (stg_a[k][CHUNK-1] ^ stg_b[k][CHUNK-1] ^ chunk_sum[CHUNK-1]);
      assign zero_d   = ~|a_rot_d;
      // The upper bits of the final b word are no longer needed.
      assign unused_b = ^stg_b[k];

      // Outputs are forced to zero when no valid operation lands. Stale
      // results therefore never linger behind out_valid=0.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (!stall) begin
          out_valid <= stg_valid[k];
          if (stg_valid[k]) begin
            sum  <= a_rot_d;
            cout <= chunk_sum[CHUNK];
            ovf  <= ovf_d;
            zero <= zero_d;
          end else begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addr
// Purpose  : Directed and streaming checks of pipelined_addr. The main
//            instance uses WIDTH=32, STAGES=4. Sibling instances use
//            STAGES=1/8/32 at WIDTH=32, plus WIDTH=8/STAGES=2. All share
//            the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addr;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  // index 0..3 -> STAGES 1, 4, 8, 32 (WIDTH 32)
  logic [3:0]       ov;
  logic [3:0]       co;
  logic [3:0]       vf;
  logic [3:0]       zr;
  logic [3:0][31:0] sm;

  logic       ov8;
  logic       co8;
  logic       vf8;
  logic       zr8;
  logic [7:0] sm8;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_addr #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .sum(sm[0]), .cout(co[0]),
    .ovf(vf[0]), .zero(zr[0]));

  pipelined_addr #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .sum(sm[1]), .cout(co[1]),
    .ovf(vf[1]), .zero(zr[1]));

  pipelined_addr #(.WIDTH(32), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .sum(sm[2]), .cout(co[2]),
    .ovf(vf[2]), .zero(zr[2]));

  pipelined_addr #(.WIDTH(32), .STAGES(32)) u_s32 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[3]), .sum(sm[3]), .cout(co[3]),
    .ovf(vf[3]), .zero(zr[3]));

  pipelined_addr #(.WIDTH(8), .STAGES(2)) u_w8 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a[7:0]),
    .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(ov8), .sum(sm8),
    .cout(co8), .ovf(vf8), .zero(zr8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Main-instance result as {cout, ovf, zero, sum}.
  function automatic logic [63:0] res4();
    return {29'b0, co[1], vf[1], zr[1], sm[1]};
  endfunction

  // Reference: {cout, ovf, zero, sum} for a w-bit add/sub (w = 8 or 32).
  function automatic logic [34:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                        input logic fc, input logic fs, input int w);
    logic [31:0] mask;
    logic [31:0] lowm;
    logic [31:0] be;
    logic [31:0] s;
    logic [32:0] full;
    logic [32:0] part;
    logic        c0;
    logic        cf;
    logic        cm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    be   = (fs ? ~fb : fb) & mask;
    c0   = fc ^ fs;
    full = {1'b0, fa & mask} + {1'b0, be} + {32'b0, c0};
    s    = full[31:0] & mask;
    cf   = full[w];
    lowm = mask >> 1;
    part = {1'b0, fa & lowm} + {1'b0, be & lowm} + {32'b0, c0};
    cm   = part[w-1];
    return {cf, cf ^ cm, (s == 32'h0), s};
  endfunction

  // One operation into the idle pipe; checks the valid edge and the result.
  task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic ts, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check({tag, " valid_early"}, {63'b0, ov[1]}, 64'd0);
    tick();
    check({tag, " valid"}, {63'b0, ov[1]}, 64'd1);
    check({tag, " result"}, res4(), {29'b0, ec, eo, ez, es});
    tick();
    check({tag, " valid_after"}, {63'b0, ov[1]}, 64'd0);
  endtask

  localparam int N = 64;
  logic [31:0] sa [N];
  logic [31:0] sb [N];
  logic        sc [N];
  logic        ss [N];
  int          lat [4] = '{1, 4, 8, 32};

  initial begin
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset valid", {63'b0, ov[1]}, 64'd0);
    check("reset outputs", res4(), 64'd0);

    directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("add_cin_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_borrow_in", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1,
             32'h0000_0006, 1'b1, 1'b0, 1'b0);
    directed("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Stall for 3 cycles right after issue: result lands 3 cycles late.
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall hold_empty", {63'b0, ov[1]}, 64'd0);
    end
    stall = 1'b0;
    repeat (2) tick();
    check("stall valid_early", {63'b0, ov[1]}, 64'd0);
    tick();
    check("stall valid", {63'b0, ov[1]}, 64'd1);
    check("stall result", res4(), {29'b0, 3'b000, 32'h0001_0000});
    // Stall with a result on the outputs; the offered op must be dropped.
    stall = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h1;
    repeat (2) begin
      tick();
      check("stall out_valid_held", {63'b0, ov[1]}, 64'd1);
      check("stall out_held", res4(), {29'b0, 3'b000, 32'h0001_0000});
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (6) begin
      tick();
      check("stall dropped_op", {63'b0, ov[1]}, 64'd0);
    end

    // Reset mid-operation: three ops, rst during the third.
    sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    a = 32'h1; b = 32'h2; tick();
    a = 32'h3; b = 32'h4; tick();
    a = 32'h5; b = 32'h6; rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (5) begin
      tick();
      check("rst_mid valid", {63'b0, ov[1]}, 64'd0);
      check("rst_mid outputs", res4(), 64'd0);
    end

    // rst and stall together: rst wins.
    a = 32'h10; b = 32'h20; in_valid = 1'b1; tick();
    in_valid = 1'b0; rst = 1'b1; stall = 1'b1; tick();
    rst = 1'b0; stall = 1'b0;
    repeat (5) begin
      tick();
      check("rst_stall valid", {63'b0, ov[1]}, 64'd0);
    end

    // Streaming: one op per cycle, checked in order on every instance.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N + 31; i++) begin
      if (i < N) begin
        sa[i] = $urandom;
        sb[i] = (i % 8 == 0) ? ~sa[i] : $urandom;
        sc[i] = 1'($urandom_range(0, 1));
        ss[i] = 1'($urandom_range(0, 1));
        a = sa[i]; b = sb[i]; cin = sc[i]; sub = ss[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      for (int d = 0; d < 4; d++) begin
        int j;
        j = i + 1 - lat[d];
        if (j >= 0 && j < N) begin
          check($sformatf("stream S%0d op%0d valid", lat[d], j), {63'b0, ov[d]}, 64'd1);
          check($sformatf("stream S%0d op%0d result", lat[d], j),
                {29'b0, co[d], vf[d], zr[d], sm[d]},
                {29'b0, model(sa[j], sb[j], sc[j], ss[j], 32)});
        end else begin
          check($sformatf("stream S%0d idle valid", lat[d]), {63'b0, ov[d]}, 64'd0);
        end
      end
      begin
        int j8;
        j8 = i - 1;
        if (j8 >= 0 && j8 < N) begin
          check($sformatf("stream W8 op%0d valid", j8), {63'b0, ov8}, 64'd1);
          check($sformatf("stream W8 op%0d result", j8),
                {29'b0, co8, vf8, zr8, 24'b0, sm8},
                {29'b0, model(sa[j8], sb[j8], sc[j8], ss[j8], 8)});
        end else begin
          check("stream W8 idle valid", {63'b0, ov8}, 64'd0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
